timer_arbiter: RTL and testbench

Shares one programmable delay timer between up to NUM_REQ game-logic requesters, such as deal-animation delay, result-display hold, LED blink and input lockout. Each requester raises a level request with a duration in ticks. The block grants the timer round-robin, counts the duration, then pulses that requester's done. It sits between the blackjack game FSM/UI blocks and the shared tick/counter datapath.

---
 rtl/timer_arbiter_pkg.sv | 40 ++++
 rtl/timer_arbiter_tick_prescaler.sv | 34 +++
 rtl/timer_arbiter.sv | 135 +++++++++++++
 tb/tb_timer_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_arbiter_pkg.sv
// Shared types and helpers for the blackjack delay-timer blocks.
package blackjack_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } tmr_state_t;

    // One millisecond tick at a 50 MHz system clock.
    localparam int TICKS_1MS_50MHZ = 50000;

    // Widest request vector any arbiter may hand to rr_pick.
    localparam int RR_MAX = 8;

    // Round-robin pick: first asserted request after ptr, wrapping modulo
    // num_req. Returns 0 when nothing is requested (callers gate on |req).
    function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] req,
                                           input logic [2:0]        ptr,
                                           input int                num_req);
        logic [2:0] pick;
        logic       found;
        int         idx;
        logic [2:0] idx3;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            if (k <= num_req) begin
                idx  = (int'(ptr) + k) % num_req;
                idx3 = idx[2:0];
                if (!found && req[idx3]) begin
                    pick  = idx3;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/timer_arbiter_tick_prescaler.sv
// Divides clk down to a one-cycle tick every PRESCALE enabled cycles.
module tick_prescaler #(
    parameter int PRESCALE = 50000,
    parameter int PS_WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [PS_WIDTH-1:0] LAST = PS_WIDTH'(PRESCALE - 1);

    logic [PS_WIDTH-1:0] count;

    // Count enabled cycles, wrapping at LAST; clear restarts the period.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + PS_WIDTH'(1);
        end
    end

    // Tick lands in the same cycle the count wraps, so the owner FSM acts on it
    // at that edge.
    assign tick = enable && (count == LAST);

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one prescaled delay timer between requesters.
module timer_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 16,
    parameter int PRESCALE = blackjack_timer_pkg::TICKS_1MS_50MHZ,
    parameter int PS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] duration,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [WIDTH-1:0]         remaining
);

    import blackjack_timer_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    tmr_state_t         state, state_next;
    logic [IDX_W-1:0]   owner, owner_next;
    logic [IDX_W-1:0]   rr_ptr, rr_next;
    logic [WIDTH-1:0]   remaining_next;
    logic [NUM_REQ-1:0] grant_next, done_next;
    logic               busy_next;

    logic [IDX_W-1:0]   winner;
    logic [WIDTH-1:0]   win_dur;
    logic [NUM_REQ-1:0] win_onehot, owner_onehot;
    logic               owner_req;
    logic               ps_clear, ps_enable, tick;

    assign winner       = IDX_W'(rr_pick(RR_MAX'(req), 3'(rr_ptr), NUM_REQ));
    assign win_dur      = duration[winner*WIDTH +: WIDTH];
    assign win_onehot   = NUM_REQ'(1) << winner;
    assign owner_onehot = NUM_REQ'(1) << owner;
    assign owner_req    = req[owner];

    // The prescaler only runs while an owner holds the timer; any other state
    // or an abort restarts it so the next owner gets a full first tick.
    assign ps_enable = (state == RUN);
    assign ps_clear  = (state != RUN) || !owner_req;

    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PS_WIDTH (PS_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (ps_clear),
        .enable (ps_enable),
        .tick   (tick)
    );

    // Next-state and next-output decode; outputs are registered below.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next     = state;
        owner_next     = owner;
        rr_next        = rr_ptr;
        remaining_next = remaining;
        grant_next     = grant;
        done_next      = '0;
        case (state)
            IDLE: begin
                grant_next     = '0;
                remaining_next = '0;
                if (|req) begin
                    owner_next     = winner;
                    rr_next        = winner;
                    remaining_next = win_dur;
                    if (win_dur != '0) begin
                        state_next = RUN;
                        grant_next = win_onehot;
                    end else begin
                        // Zero-length request completes without ever granting.
                        state_next = DONE;
                        done_next  = win_onehot;
                    end
                end
            end
            RUN: begin
                if (!owner_req) begin
                    // Owner withdrew: release silently, rr_ptr unchanged.
                    state_next     = IDLE;
                    grant_next     = '0;
                    remaining_next = '0;
                end else if (tick) begin
                    remaining_next = remaining - WIDTH'(1);
                    if (remaining == WIDTH'(1)) begin
                        state_next = DONE;
                        grant_next = '0;
                        done_next  = owner_onehot;
                    end
                end
            end
            DONE: begin
                state_next     = IDLE;
                grant_next     = '0;
                remaining_next = '0;
            end
            default: begin
                state_next     = IDLE;
                grant_next     = '0;
                remaining_next = '0;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // State, arbitration pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            remaining <= '0;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            rr_ptr    <= rr_next;
            remaining <= remaining_next;
            grant     <= grant_next;
            done      <= done_next;
            busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: stimulus queues expected grant/done
// events and output snapshots; a negedge monitor pops and compares them.
module tb_timer_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int PS = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [NR*W-1:0] duration = '0;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   done;
    logic            busy;
    logic [W-1:0]    remaining;

    timer_arbiter #(
        .NUM_REQ  (NR),
        .WIDTH    (W),
        .PRESCALE (PS),
        .PS_WIDTH (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .duration  (duration),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    // cyc == n between rising edge n and n+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic [3:0] d;
        logic       b;
        logic [7:0] r;
    } snap_t;

    typedef struct {
        bit         is_done;
        logic [3:0] vec;
        int         cyc;
    } ev_t;

    snap_t snapq[$];
    ev_t   evq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_snap(input int c, input logic [3:0] g, input logic [3:0] d,
                             input logic b, input logic [7:0] r);
        snap_t s;
        s.cyc = c; s.g = g; s.d = d; s.b = b; s.r = r;
        snapq.push_back(s);
    endtask

    task automatic push_ev(input bit is_done, input logic [3:0] vec, input int c);
        ev_t e;
        e.is_done = is_done; e.vec = vec; e.cyc = c;
        evq.push_back(e);
    endtask

    task automatic set_dur(input int i, input logic [7:0] v);
        duration[i*W +: W] = v;
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic mon_event(input bit is_done, input logic [3:0] vec);
        ev_t e;
        if (evq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s: got %b at cycle %0d expected none",
                     is_done ? "done" : "grant", vec, cyc);
        end else begin
            e = evq.pop_front();
            check(is_done ? "done_evt" : "grant_evt",
                  64'({7'd0, is_done, 4'd0, vec, 32'(cyc)}),
                  64'({7'd0, e.is_done, 4'd0, e.vec, 32'(e.cyc)}));
        end
    endtask

    // Monitor: snapshots at their scheduled cycle, plus every grant rise and
    // done pulse matched against the event queue in order.
    logic [3:0] grant_prev = '0;
    always @(negedge clk) begin
        snap_t      s;
        logic [3:0] rise;
        if (snapq.size() != 0 && snapq[0].cyc == cyc) begin
            s = snapq.pop_front();
            check($sformatf("snap@%0d {grant,done,busy,rem}", s.cyc),
                  64'({grant, done, busy, remaining}),
                  64'({s.g, s.d, s.b, s.r}));
        end
        rise = grant & ~grant_prev;
        if (rise != '0) mon_event(1'b0, rise);
        if (done != '0) mon_event(1'b1, done);
        grant_prev = grant;
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish by cycle 110 (cycle %0d)", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        // Reset held across edges 1..3.
        push_snap(2, 4'b0000, 4'b0000, 1'b0, 8'd0);
        push_snap(4, 4'b0000, 4'b0000, 1'b0, 8'd0);
        goto(3);
        reset = 1'b1;

        // 1: requester 0, duration 3 -> RUN 6..17, done at 18.
        goto(5);
        set_dur(0, 8'd3);
        req = 4'b0001;
        push_ev(1'b0, 4'b0001, 6);
        push_ev(1'b1, 4'b0001, 18);
        push_snap(6,  4'b0001, 4'b0000, 1'b1, 8'd3);
        push_snap(9,  4'b0001, 4'b0000, 1'b1, 8'd3);
        push_snap(10, 4'b0001, 4'b0000, 1'b1, 8'd2);
        push_snap(14, 4'b0001, 4'b0000, 1'b1, 8'd1);
        push_snap(17, 4'b0001, 4'b0000, 1'b1, 8'd1);
        push_snap(18, 4'b0000, 4'b0001, 1'b1, 8'd0);
        push_snap(19, 4'b0000, 4'b0000, 1'b0, 8'd0);
        goto(18);
        req = 4'b0000;

        // 2: requesters 1 and 2 together, duration 1 each.
        goto(21);
        set_dur(1, 8'd1);
        set_dur(2, 8'd1);
        req = 4'b0110;
        push_ev(1'b0, 4'b0010, 22);
        push_ev(1'b1, 4'b0010, 26);
        push_ev(1'b0, 4'b0100, 28);
        push_ev(1'b1, 4'b0100, 32);
        push_snap(25, 4'b0010, 4'b0000, 1'b1, 8'd1);
        push_snap(26, 4'b0000, 4'b0010, 1'b1, 8'd0);
        push_snap(27, 4'b0000, 4'b0000, 1'b0, 8'd0);
        push_snap(28, 4'b0100, 4'b0000, 1'b1, 8'd1);
        goto(26);
        req[1] = 1'b0;
        goto(32);
        req[2] = 1'b0;

        // 3: zero duration goes straight to done, never granted.
        goto(34);
        set_dur(3, 8'd0);
        req = 4'b1000;
        push_ev(1'b1, 4'b1000, 35);
        push_snap(35, 4'b0000, 4'b1000, 1'b1, 8'd0);
        push_snap(36, 4'b0000, 4'b0000, 1'b0, 8'd0);
        goto(35);
        req = 4'b0000;

        // 4: abort by requester 0 at RUN cycle 6; pending requester 2 follows.
        goto(38);
        set_dur(0, 8'd5);
        set_dur(2, 8'd2);
        req = 4'b0101;
        push_ev(1'b0, 4'b0001, 39);
        push_ev(1'b0, 4'b0100, 46);
        push_ev(1'b1, 4'b0100, 54);
        push_snap(39, 4'b0001, 4'b0000, 1'b1, 8'd5);
        push_snap(44, 4'b0001, 4'b0000, 1'b1, 8'd4);
        push_snap(45, 4'b0000, 4'b0000, 1'b0, 8'd0);
        push_snap(46, 4'b0100, 4'b0000, 1'b1, 8'd2);
        goto(40);
        set_dur(0, 8'd9);            // ignored while running
        goto(44);
        req[0] = 1'b0;
        goto(54);
        req = 4'b0000;

        // 5: reset mid-RUN at remaining 2; afterwards 0 beats 3.
        goto(56);
        set_dur(1, 8'd4);
        req = 4'b0010;
        push_ev(1'b0, 4'b0010, 57);
        push_ev(1'b0, 4'b0001, 69);
        push_ev(1'b1, 4'b0001, 73);
        push_snap(66, 4'b0010, 4'b0000, 1'b1, 8'd2);
        push_snap(67, 4'b0000, 4'b0000, 1'b0, 8'd0);
        push_snap(68, 4'b0000, 4'b0000, 1'b0, 8'd0);
        push_snap(69, 4'b0001, 4'b0000, 1'b1, 8'd1);
        goto(66);
        reset = 1'b0;
        set_dur(0, 8'd1);
        set_dur(3, 8'd2);
        req = 4'b1001;
        goto(68);
        reset = 1'b1;
        goto(73);
        req[0] = 1'b0;

        // 6: requester 3 held alone with duration 2 -> period 10.
        push_ev(1'b0, 4'b1000, 75);
        push_ev(1'b1, 4'b1000, 83);
        push_ev(1'b0, 4'b1000, 85);
        push_ev(1'b1, 4'b1000, 93);
        push_ev(1'b0, 4'b1000, 95);
        push_ev(1'b1, 4'b1000, 103);
        push_snap(82, 4'b1000, 4'b0000, 1'b1, 8'd1);
        push_snap(83, 4'b0000, 4'b1000, 1'b1, 8'd0);
        push_snap(84, 4'b0000, 4'b0000, 1'b0, 8'd0);
        push_snap(85, 4'b1000, 4'b0000, 1'b1, 8'd2);
        goto(103);
        req = 4'b0000;
        push_snap(105, 4'b0000, 4'b0000, 1'b0, 8'd0);

        goto(110);
        check("events_left", 64'(evq.size()), 64'd0);
        check("snaps_left", 64'(snapq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
